// File: rtl/branch_cond_unit.sv
// branch_cond_unit: resolves Bicc conditional branches against N/Z/V/C flags and issues the fetch redirect
// Ports: clk, rst (asynchronous, active-low); br_valid/br_ready accept handshake;
//   br_cond, br_annul, br_disp, br_pc branch operands; n, z, v, c status flags;
//   br_done result strobe with br_taken, pc_load, pc_target, annul_slot.
// Optional: define BRANCH_STATS_EN to add saturating stat_taken / stat_not_taken counters.
module branch_cond_unit #(
  parameter int PC_W   = 32,
  parameter int DISP_W = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [3:0]        br_cond,
  input  logic              br_annul,
  input  logic [DISP_W-1:0] br_disp,
  input  logic [PC_W-1:0]   br_pc,
  input  logic              n,
  input  logic              z,
  input  logic              v,
  input  logic              c,
  output logic              br_done,
  output logic              br_taken,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_target,
  output logic              annul_slot
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       stat_taken,
  output logic [15:0]       stat_not_taken
`endif
);
  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, RESOLVE = 2'd2} state_t;
  state_t              state_q, state_d;
  logic [3:0]          cond_q, cond_d;
  logic                annul_q, annul_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                taken_q, taken_d;
  logic [PC_W-1:0]     target_q, target_d;
  logic                annul_slot_q, annul_slot_d;
  logic [7:0]          cond_tbl;
  logic                cond_true;
  logic [PC_W-1:0]     disp_ext;
  // cond[2:0] selects the base test, cond[3] inverts it (0000 never / 1000 always)
  assign cond_tbl  = {v, n, c, c | z, n ^ v, z | (n ^ v), z, 1'b0};
  assign cond_true = cond_tbl[cond_q[2:0]] ^ cond_q[3];
  assign disp_ext  = {{(PC_W-DISP_W){disp_q[DISP_W-1]}}, disp_q};
  always_comb begin
    state_d      = state_q;
    cond_d       = cond_q;
    annul_d      = annul_q;
    disp_d       = disp_q;
    pc_d         = pc_q;
    taken_d      = taken_q;
    target_d     = target_q;
    annul_slot_d = annul_slot_q;
    case (state_q)
      IDLE: if (br_valid) begin
        cond_d  = br_cond;
        annul_d = br_annul;
        disp_d  = br_disp;
        pc_d    = br_pc;
        state_d = EVAL;
      end
      EVAL: begin
        taken_d      = cond_true;
        target_d     = pc_q + (disp_ext << 2);
        annul_slot_d = annul_q & (~cond_true | (cond_q == 4'b1000));
        state_d      = RESOLVE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cond_q       <= '0;
      annul_q      <= 1'b0;
      disp_q       <= '0;
      pc_q         <= '0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      annul_slot_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cond_q       <= cond_d;
      annul_q      <= annul_d;
      disp_q       <= disp_d;
      pc_q         <= pc_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      annul_slot_q <= annul_slot_d;
    end
  end
  assign br_ready   = state_q == IDLE;
  assign br_done    = state_q == RESOLVE;
  assign br_taken   = taken_q;
  assign pc_load    = br_done & taken_q;
  assign pc_target  = target_q;
  assign annul_slot = annul_slot_q;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_taken_q, stat_taken_d, stat_not_taken_q, stat_not_taken_d;
  always_comb begin
    stat_taken_d     = (br_done && taken_q && stat_taken_q != 16'hFFFF) ? stat_taken_q + 16'd1 : stat_taken_q;
    stat_not_taken_d = (br_done && !taken_q && stat_not_taken_q != 16'hFFFF) ? stat_not_taken_q + 16'd1 : stat_not_taken_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
    end else begin
      stat_taken_q     <= stat_taken_d;
      stat_not_taken_q <= stat_not_taken_d;
    end
  end
  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_not_taken_q;
`endif
endmodule
